// File: rtl/alarm_pkg.sv
// Shared codes for the alarm-set sequencer: mode flags, cursor codes, state encoding.
package alarm_pkg;

    localparam logic [2:0] FLAG_IDLE  = 3'b000;
    localparam logic [2:0] FLAG_ALARM = 3'b011;

    localparam logic [2:0] CONT_HOUR = 3'b001;
    localparam logic [2:0] CONT_MIN  = 3'b010;
    localparam logic [2:0] CONT_SEC  = 3'b011;
    localparam logic [2:0] CONT_MER  = 3'b100;

    // State codes double as the FLAG output value.
    typedef enum logic [2:0] {
        ST_IDLE = FLAG_IDLE,
        ST_SET  = FLAG_ALARM
    } state_t;

    function automatic logic [2:0] next_cursor(input logic [2:0] cur);
        case (cur)
            CONT_HOUR: return CONT_MIN;
            CONT_MIN:  return CONT_SEC;
            CONT_SEC:  return CONT_MER;
            default:   return CONT_HOUR;
        endcase
    endfunction

endpackage

// File: rtl/alarm_key_edge.sv
// Per-key sampler with rising-edge press detect; optional hold auto-repeat
// timer built only when ALARM_SET_AUTOREPEAT_EN is defined.
module alarm_key_edge #(
    parameter int unsigned REPEAT_DLY = 1000,
    parameter int unsigned REPEAT_PER = 200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic level,
    output logic press,
    output logic rep
);

    logic sample;
    logic prev;
    logic primed;

    // First edge after reset loads history from the key itself, so a key
    // held through reset release is not seen as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= 1'b0;
            prev   <= 1'b0;
            primed <= 1'b0;
        end else begin
            sample <= key;
            prev   <= primed ? sample : key;
            primed <= 1'b1;
        end
    end

    assign level = sample;
    assign press = sample & ~prev;

`ifdef ALARM_SET_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rcnt;
    logic          armed;
    logic          repeating;
    logic          held;

    assign held = sample & prev;
    assign rep  = held & armed &
                  (repeating ? (rcnt == RW'(REPEAT_PER)) : (rcnt == RW'(REPEAT_DLY)));

    // rcnt equals the number of cycles since the press (or last repeat).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt      <= '0;
            armed     <= 1'b0;
            repeating <= 1'b0;
        end else if (!sample) begin
            rcnt      <= '0;
            armed     <= 1'b0;
            repeating <= 1'b0;
        end else if (press) begin
            rcnt      <= RW'(1);
            armed     <= 1'b1;
            repeating <= 1'b0;
        end else if (armed) begin
            if (rep) begin
                rcnt      <= RW'(1);
                repeating <= 1'b1;
            end else begin
                rcnt <= rcnt + RW'(1);
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{REPEAT_DLY, REPEAT_PER};
    assign rep        = 1'b0;
`endif

endmodule

// File: rtl/alarm_set_seq.sv
// Alarm-set sequencer: IDLE/SET FSM driving cursor, one-cycle UP/DOWN commands,
// blink and inactivity timeout. Auto-repeat is enabled by ALARM_SET_AUTOREPEAT_EN.
module alarm_set_seq
    import alarm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 10000,
    parameter int unsigned BLINK_CYC   = 500,
    parameter int unsigned REPEAT_DLY  = 1000,
    parameter int unsigned REPEAT_PER  = 200
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       KEY_MODE,
    input  logic       KEY_SEL,
    input  logic       KEY_UP,
    input  logic       KEY_DOWN,
    output logic [2:0] FLAG,
    output logic [2:0] UP,
    output logic [2:0] DOWN,
    output logic [2:0] CURSOR,
    output logic       BLINK
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BW = $clog2(BLINK_CYC + 1);

    logic mode_lvl, mode_p, mode_rep;
    logic sel_lvl, sel_p, sel_rep;
    logic up_lvl, up_p, up_rep;
    logic dn_lvl, dn_p, dn_rep;

    alarm_key_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_mode (
        .clk(CLK), .rst_n(RESETN), .key(KEY_MODE),
        .level(mode_lvl), .press(mode_p), .rep(mode_rep)
    );
    alarm_key_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_sel (
        .clk(CLK), .rst_n(RESETN), .key(KEY_SEL),
        .level(sel_lvl), .press(sel_p), .rep(sel_rep)
    );
    alarm_key_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_up (
        .clk(CLK), .rst_n(RESETN), .key(KEY_UP),
        .level(up_lvl), .press(up_p), .rep(up_rep)
    );
    alarm_key_edge #(.REPEAT_DLY(REPEAT_DLY), .REPEAT_PER(REPEAT_PER)) u_down (
        .clk(CLK), .rst_n(RESETN), .key(KEY_DOWN),
        .level(dn_lvl), .press(dn_p), .rep(dn_rep)
    );

    logic unused_keys;
    assign unused_keys = ^{mode_lvl, mode_rep, sel_lvl, sel_rep};

    state_t        state, state_n;
    logic [2:0]    cursor, cursor_n;
    logic [2:0]    up_q, up_n;
    logic [2:0]    dn_q, dn_n;
    logic          blink, blink_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          up_ev, dn_ev, any_ev;

    assign up_ev  = up_p | up_rep;
    assign dn_ev  = dn_p | dn_rep;
    assign any_ev = mode_p | sel_p | up_ev | dn_ev;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state  <= ST_IDLE;
            cursor <= CONT_HOUR;
            up_q   <= '0;
            dn_q   <= '0;
            blink  <= 1'b0;
            bcnt   <= '0;
            tcnt   <= '0;
        end else begin
            state  <= state_n;
            cursor <= cursor_n;
            up_q   <= up_n;
            dn_q   <= dn_n;
            blink  <= blink_n;
            bcnt   <= bcnt_n;
            tcnt   <= tcnt_n;
        end
    end

    always_comb begin
        state_n  = state;
        cursor_n = cursor;
        up_n     = '0;
        dn_n     = '0;
        blink_n  = 1'b0;
        bcnt_n   = '0;
        tcnt_n   = '0;
        case (state)
            ST_IDLE: begin
                if (mode_p) begin
                    state_n  = ST_SET;
                    cursor_n = CONT_HOUR;
                    blink_n  = 1'b1;
                end
            end
            ST_SET: begin
                if (bcnt == BW'(BLINK_CYC - 1)) begin
                    blink_n = ~blink;
                    bcnt_n  = '0;
                end else begin
                    blink_n = blink;
                    bcnt_n  = bcnt + BW'(1);
                end
                // Priority MODE > SEL > UP/DOWN; any press also clears the timeout.
                if (mode_p) begin
                    state_n = ST_IDLE;
                    blink_n = 1'b0;
                    bcnt_n  = '0;
                end else if (any_ev) begin
                    if (sel_p) begin
                        cursor_n = next_cursor(cursor);
                        blink_n  = 1'b1;
                        bcnt_n   = '0;
                    end else if (up_ev && !dn_lvl) begin
                        up_n = cursor;
                    end else if (dn_ev && !up_lvl) begin
                        dn_n = cursor;
                    end
                end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    state_n = ST_IDLE;
                    blink_n = 1'b0;
                    bcnt_n  = '0;
                end else begin
                    tcnt_n = tcnt + TW'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign FLAG   = state;
    assign UP     = up_q;
    assign DOWN   = dn_q;
    assign CURSOR = cursor;
    assign BLINK  = blink;

endmodule

// File: tb/tb_alarm_set_seq.sv
// Directed self-checking bench for alarm_set_seq; expectations follow
// ALARM_SET_AUTOREPEAT_EN when it is defined for the build.
module tb_alarm_set_seq;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic       KEY_MODE = 1'b0;
    logic       KEY_SEL = 1'b0;
    logic       KEY_UP = 1'b0;
    logic       KEY_DOWN = 1'b0;
    logic [2:0] FLAG, UP, DOWN, CURSOR;
    logic       BLINK;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    alarm_set_seq #(
        .TIMEOUT_CYC(20),
        .BLINK_CYC(4),
        .REPEAT_DLY(10),
        .REPEAT_PER(4)
    ) dut (
        .CLK(CLK), .RESETN(RESETN),
        .KEY_MODE(KEY_MODE), .KEY_SEL(KEY_SEL), .KEY_UP(KEY_UP), .KEY_DOWN(KEY_DOWN),
        .FLAG(FLAG), .UP(UP), .DOWN(DOWN), .CURSOR(CURSOR), .BLINK(BLINK)
    );

    // Drive the chosen keys for one sampled cycle; returns on the press-cycle negedge.
    task automatic tap(input logic m, input logic s, input logic u, input logic d);
        KEY_MODE = m; KEY_SEL = s; KEY_UP = u; KEY_DOWN = d;
        @(negedge CLK);
        KEY_MODE = 1'b0; KEY_SEL = 1'b0; KEY_UP = 1'b0; KEY_DOWN = 1'b0;
    endtask

    task automatic test_reset;
        RESETN = 1'b0;
        repeat (3) @(negedge CLK);
        checks++; if (FLAG !== 3'b000) begin errors++; $display("FAIL reset_flag got=%b exp=%b", FLAG, 3'b000); end
        checks++; if (UP !== 3'b000) begin errors++; $display("FAIL reset_up got=%b exp=%b", UP, 3'b000); end
        checks++; if (DOWN !== 3'b000) begin errors++; $display("FAIL reset_down got=%b exp=%b", DOWN, 3'b000); end
        checks++; if (CURSOR !== 3'b001) begin errors++; $display("FAIL reset_cursor got=%b exp=%b", CURSOR, 3'b001); end
        checks++; if (BLINK !== 1'b0) begin errors++; $display("FAIL reset_blink got=%b exp=%b", BLINK, 1'b0); end
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_cursor_walk;
        logic [2:0] exp_cur [4];
        exp_cur = '{3'b010, 3'b011, 3'b100, 3'b001};
        tap(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++; if (FLAG !== 3'b011) begin errors++; $display("FAIL enter_flag got=%b exp=%b", FLAG, 3'b011); end
        checks++; if (CURSOR !== 3'b001) begin errors++; $display("FAIL enter_cursor got=%b exp=%b", CURSOR, 3'b001); end
        checks++; if (BLINK !== 1'b1) begin errors++; $display("FAIL enter_blink got=%b exp=%b", BLINK, 1'b1); end
        for (int i = 0; i < 4; i++) begin
            tap(1'b0, 1'b1, 1'b0, 1'b0);
            @(negedge CLK);
            checks++;
            if (CURSOR !== exp_cur[i]) begin
                errors++; $display("FAIL sel_cursor[%0d] got=%b exp=%b", i, CURSOR, exp_cur[i]);
            end
            checks++; if (FLAG !== 3'b011) begin errors++; $display("FAIL sel_flag[%0d] got=%b exp=%b", i, FLAG, 3'b011); end
        end
        // Blink restarted high by the last SEL: high for 4 cycles, low for 4.
        repeat (3) @(negedge CLK);
        checks++; if (BLINK !== 1'b1) begin errors++; $display("FAIL blink_c4 got=%b exp=%b", BLINK, 1'b1); end
        @(negedge CLK);
        checks++; if (BLINK !== 1'b0) begin errors++; $display("FAIL blink_c5 got=%b exp=%b", BLINK, 1'b0); end
        repeat (4) @(negedge CLK);
        checks++; if (BLINK !== 1'b1) begin errors++; $display("FAIL blink_c9 got=%b exp=%b", BLINK, 1'b1); end
    endtask

    task automatic test_up_pulse;
        tap(1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++; if (CURSOR !== 3'b010) begin errors++; $display("FAIL up_setup_cursor got=%b exp=%b", CURSOR, 3'b010); end
        KEY_UP = 1'b1;
        @(negedge CLK);
        KEY_UP = 1'b0;
        checks++; if (UP !== 3'b000) begin errors++; $display("FAIL up_c0 got=%b exp=%b", UP, 3'b000); end
        @(negedge CLK);
        checks++; if (UP !== 3'b010) begin errors++; $display("FAIL up_c1 got=%b exp=%b", UP, 3'b010); end
        checks++; if (DOWN !== 3'b000) begin errors++; $display("FAIL up_c1_down got=%b exp=%b", DOWN, 3'b000); end
        @(negedge CLK);
        checks++; if (UP !== 3'b000) begin errors++; $display("FAIL up_c2 got=%b exp=%b", UP, 3'b000); end
        checks++; if (DOWN !== 3'b000) begin errors++; $display("FAIL up_c2_down got=%b exp=%b", DOWN, 3'b000); end
        tap(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        checks++; if (DOWN !== 3'b010) begin errors++; $display("FAIL down_c1 got=%b exp=%b", DOWN, 3'b010); end
        checks++; if (UP !== 3'b000) begin errors++; $display("FAIL down_c1_up got=%b exp=%b", UP, 3'b000); end
        @(negedge CLK);
        checks++; if (DOWN !== 3'b000) begin errors++; $display("FAIL down_c2 got=%b exp=%b", DOWN, 3'b000); end
    endtask

    task automatic test_conflict;
        tap(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 2; i++) begin
            @(negedge CLK);
            checks++; if (UP !== 3'b000) begin errors++; $display("FAIL both_up[%0d] got=%b exp=%b", i, UP, 3'b000); end
            checks++; if (DOWN !== 3'b000) begin errors++; $display("FAIL both_down[%0d] got=%b exp=%b", i, DOWN, 3'b000); end
        end
        KEY_UP = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (UP !== 3'b010) begin errors++; $display("FAIL hold_up_c1 got=%b exp=%b", UP, 3'b010); end
        @(negedge CLK);
        KEY_DOWN = 1'b1;
        @(negedge CLK);
        KEY_DOWN = 1'b0;
        @(negedge CLK);
        KEY_UP = 1'b0;
        checks++; if (DOWN !== 3'b000) begin errors++; $display("FAIL held_down got=%b exp=%b", DOWN, 3'b000); end
        checks++; if (UP !== 3'b000) begin errors++; $display("FAIL held_up got=%b exp=%b", UP, 3'b000); end
        tap(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++; if (FLAG !== 3'b000) begin errors++; $display("FAIL modesel_flag got=%b exp=%b", FLAG, 3'b000); end
        checks++; if (CURSOR !== 3'b010) begin errors++; $display("FAIL modesel_cursor got=%b exp=%b", CURSOR, 3'b010); end
        checks++; if (BLINK !== 1'b0) begin errors++; $display("FAIL modesel_blink got=%b exp=%b", BLINK, 1'b0); end
        tap(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        checks++; if (UP !== 3'b000) begin errors++; $display("FAIL idle_up got=%b exp=%b", UP, 3'b000); end
        checks++; if (FLAG !== 3'b000) begin errors++; $display("FAIL idle_flag got=%b exp=%b", FLAG, 3'b000); end
    endtask

    task automatic test_timeout;
        logic [2:0] exp_flag;
        tap(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            @(negedge CLK);
            exp_flag = (k <= 20) ? 3'b011 : 3'b000;
            checks++;
            if (FLAG !== exp_flag) begin
                errors++; $display("FAIL timeout_flag[%0d] got=%b exp=%b", k, FLAG, exp_flag);
            end
            if (k == 1) begin
                checks++; if (CURSOR !== 3'b001) begin errors++; $display("FAIL reload_cursor got=%b exp=%b", CURSOR, 3'b001); end
            end
        end
    endtask

    task automatic test_repeat;
        logic       hit;
        logic [2:0] exp_up;
        tap(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        KEY_UP = 1'b1;
        for (int i = 0; i <= 35; i++) begin
            @(negedge CLK);
`ifdef ALARM_SET_AUTOREPEAT_EN
            hit = (i == 1) || (i >= 11 && i <= 27 && ((i - 11) % 4) == 0);
`else
            hit = (i == 1);
`endif
            exp_up = hit ? 3'b001 : 3'b000;
            checks++;
            if (UP !== exp_up) begin
                errors++; $display("FAIL repeat_up[%0d] got=%b exp=%b", i, UP, exp_up);
            end
            checks++; if (DOWN !== 3'b000) begin errors++; $display("FAIL repeat_down[%0d] got=%b exp=%b", i, DOWN, 3'b000); end
            if (i == 29) KEY_UP = 1'b0;
        end
    endtask

    task automatic test_reset_mid;
        RESETN = 1'b0;
        @(negedge CLK);
        RESETN = 1'b1;
        repeat (2) @(negedge CLK);
        tap(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        KEY_UP = 1'b1;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        checks++; if (UP !== 3'b001) begin errors++; $display("FAIL mid_pulse got=%b exp=%b", UP, 3'b001); end
        #2 RESETN = 1'b0;
        #1;
        checks++; if (UP !== 3'b000) begin errors++; $display("FAIL mid_trunc_up got=%b exp=%b", UP, 3'b000); end
        checks++; if (FLAG !== 3'b000) begin errors++; $display("FAIL mid_flag got=%b exp=%b", FLAG, 3'b000); end
        checks++; if (CURSOR !== 3'b001) begin errors++; $display("FAIL mid_cursor got=%b exp=%b", CURSOR, 3'b001); end
        checks++; if (BLINK !== 1'b0) begin errors++; $display("FAIL mid_blink got=%b exp=%b", BLINK, 1'b0); end
        @(negedge CLK);
        RESETN = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            checks++; if (UP !== 3'b000) begin errors++; $display("FAIL post_rst_up[%0d] got=%b exp=%b", i, UP, 3'b000); end
        end
        // Enter SET with UP still held since before reset: no command may appear.
        KEY_MODE = 1'b1;
        @(negedge CLK);
        KEY_MODE = 1'b0;
        @(negedge CLK);
        checks++; if (FLAG !== 3'b011) begin errors++; $display("FAIL held_set_flag got=%b exp=%b", FLAG, 3'b011); end
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            checks++; if (UP !== 3'b000) begin errors++; $display("FAIL held_set_up[%0d] got=%b exp=%b", i, UP, 3'b000); end
        end
        KEY_UP = 1'b0;
        repeat (2) @(negedge CLK);
        tap(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        checks++; if (UP !== 3'b001) begin errors++; $display("FAIL fresh_up got=%b exp=%b", UP, 3'b001); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge CLK);
        test_reset();
        test_cursor_walk();
        test_up_pulse();
        test_conflict();
        test_timeout();
        test_repeat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
